dec_key_schedule: RTL and testbench

//  Upstream key stage for the decipher core. Expands a cipher key into all

---
 rtl/dec_key_schedule_pkg.sv | 64 ++++++
 rtl/dec_key_schedule_if.sv | 40 ++++
 rtl/dec_key_schedule_word_gen.sv | 72 +++++++
 rtl/dec_key_schedule.sv | 151 +++++++++++++++
 tb/tb_dec_key_schedule.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dec_key_schedule_pkg.sv
// ---------------------------------------------------------------------------
// dec_key_schedule_pkg
//   Shared AES constants, the state encoding of the key-schedule FSM and the
//   forward S-box used by the key expansion.
//   Build option: DKS_AES256_EN enables AES-256 support (Nk=8, Nr=14) and
//   sizes the round-key storage for 15 round keys; without it only AES-128
//   (Nk=4, Nr=10) is built and 11 round keys are stored.
// ---------------------------------------------------------------------------
package dec_key_schedule_pkg;

  localparam int BYTE_S         = 8;
  localparam int WORD_S         = 32;
  localparam int BLK_S          = 128;
  localparam int NB             = 4;      // words per block / round key
  localparam int ROUND_KEY_BITS = BLK_S;
  localparam int MAX_RK         = 15;     // Nr+1 for AES-256
  localparam int KEY_W          = 256;

  localparam logic [3:0] NK128 = 4'd4;
  localparam logic [3:0] NK256 = 4'd8;
  localparam logic [3:0] NR128 = 4'd10;
  localparam logic [3:0] NR256 = 4'd14;

  // Index of the last expanded word: 4*(Nr+1)-1.
  localparam logic [5:0] LAST128 = 6'd43;
  localparam logic [5:0] LAST256 = 6'd59;

`ifdef DKS_AES256_EN
  localparam int RF_WORDS = MAX_RK * NB;   // 60 words
  localparam int NK_MAX   = 8;
`else
  localparam int RF_WORDS = (int'(NR128) + 1) * NB;  // 44 words, entries 11..14 absent
  localparam int NK_MAX   = 4;
`endif

  typedef enum logic {
    IDLE,
    EXPAND
  } dks_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] get_sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/dec_key_schedule_if.sv
// ---------------------------------------------------------------------------
// dec_key_schedule_if
//   Key-load and round-key read bundle between the decipher side (master)
//   and the key schedule (slave).
//   key_start    1-cycle pulse, latches key_in (and key_256)
//   key_in       cipher key, FIPS-197 byte 0 at [7:0]
//   key_256      1 = AES-256 (only with DKS_AES256_EN)
//   rd_round     round index to read
//   round_key    registered round key for rd_round
//   rounds_total Nr for the loaded key
//   key_valid    all round keys written
//   busy         expansion in progress
// ---------------------------------------------------------------------------
interface dec_key_schedule_if;
  import dec_key_schedule_pkg::*;

  logic                      key_start;
  logic [KEY_W-1:0]          key_in;
`ifdef DKS_AES256_EN
  logic                      key_256;
`endif
  logic [3:0]                rd_round;
  logic [ROUND_KEY_BITS-1:0] round_key;
  logic [3:0]                rounds_total;
  logic                      key_valid;
  logic                      busy;

`ifdef DKS_AES256_EN
  modport master (output key_start, key_in, key_256, rd_round,
                  input  round_key, rounds_total, key_valid, busy);
  modport slave  (input  key_start, key_in, key_256, rd_round,
                  output round_key, rounds_total, key_valid, busy);
`else
  modport master (output key_start, key_in, rd_round,
                  input  round_key, rounds_total, key_valid, busy);
  modport slave  (input  key_start, key_in, rd_round,
                  output round_key, rounds_total, key_valid, busy);
`endif

endinterface

// File: rtl/dec_key_schedule_word_gen.sv
// ---------------------------------------------------------------------------
// dks_word_gen
//   Combinational next-word function of the AES key expansion:
//   w_next = w_back ^ f(w_prev), with f chosen from word index i and Nk.
//   w_prev  in  32  w[i-1]
//   w_back  in  32  w[i-Nk]
//   i       in  6   index of the word being generated
//   nk      in  4   key length in words (4 or 8)
//   w_next  out 32  w[i]
// ---------------------------------------------------------------------------
module dks_word_gen
  import dec_key_schedule_pkg::*;
(
  input  logic [WORD_S-1:0] w_prev,
  input  logic [WORD_S-1:0] w_back,
  input  logic [5:0]        i,
  input  logic [3:0]        nk,
  output logic [WORD_S-1:0] w_next
);

  // Byte 0 takes byte 1; byte 0 wraps to byte 3.
  function automatic logic [WORD_S-1:0] rot_word(input logic [WORD_S-1:0] w);
    return {w[7:0], w[31:8]};
  endfunction

  function automatic logic [WORD_S-1:0] sub_word(input logic [WORD_S-1:0] w);
    logic [WORD_S-1:0] s;
    for (int b = 0; b < 4; b++) begin
      s[BYTE_S*b +: BYTE_S] = get_sbox(w[BYTE_S*b +: BYTE_S]);
    end
    return s;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic              is_256;
  logic              at_key_boundary;  // i % Nk == 0
  logic              at_half;          // Nk == 8 and i % 8 == 4
  logic [3:0]        rc_idx;           // i / Nk
  logic [WORD_S-1:0] f;

  // NOTE: every output of a combinational block gets a default first, so no
  // path can leave a value unassigned and infer a latch.
  always_comb begin
    is_256          = (nk == NK256);
    at_key_boundary = is_256 ? (i[2:0] == 3'd0) : (i[1:0] == 2'd0);
    at_half         = is_256 && (i[2:0] == 3'd4);
    rc_idx          = is_256 ? {1'b0, i[5:3]} : i[5:2];
    f               = w_prev;
    if (at_key_boundary) begin
      f = sub_word(rot_word(w_prev)) ^ {24'h0, rcon(rc_idx)};
    end else if (at_half) begin
      f = sub_word(w_prev);
    end
    w_next = w_back ^ f;
  end

endmodule

// File: rtl/dec_key_schedule.sv
// ---------------------------------------------------------------------------
// dec_key_schedule
//   Expands a cipher key into all round keys, one 32-bit word per clock,
//   stores them, and serves round_key[rd_round] with one cycle of latency.
//   Build option: DKS_AES256_EN adds key_256 and AES-256 (rounds_total=14);
//   without it the key is AES-128 only and rounds 11..15 read as zero.
//   clk      in  clock
//   reset_n  in  asynchronous, active-low reset
//   bus      slave side of dec_key_schedule_if (key load, read port, status)
// ---------------------------------------------------------------------------
module dec_key_schedule
  import dec_key_schedule_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  dec_key_schedule_if.slave bus
);

  dks_state_e                state, state_nxt;
  logic [5:0]                idx;          // index i of the word written next
  logic                      fin;          // last word written on the previous edge
  logic                      key_valid_q;
  logic [ROUND_KEY_BITS-1:0] round_key_q;
  logic [WORD_S-1:0]         rf [RF_WORDS];

  logic [3:0]        nk;          // Nk of the key being expanded
  logic [3:0]        nk_new;      // Nk of the key on key_in
  logic [5:0]        last_idx;
  logic [3:0]        rounds_total;
  logic              start_ok;
  logic              last_wr;
  logic [WORD_S-1:0] w_prev, w_back, w_next;
  logic [5:0]        rd_base;

`ifdef DKS_AES256_EN
  logic aes256_q;

  assign nk           = aes256_q ? NK256 : NK128;
  assign nk_new       = bus.key_256 ? NK256 : NK128;
  assign last_idx     = aes256_q ? LAST256 : LAST128;
  assign rounds_total = aes256_q ? NR256 : NR128;
`else
  logic unused_key_hi;

  assign nk            = NK128;
  assign nk_new        = NK128;
  assign last_idx      = LAST128;
  assign rounds_total  = NR128;
  // The upper key half has no function in an AES-128-only build.
  assign unused_key_hi = ^bus.key_in[KEY_W-1:BLK_S];
`endif

  // A key is accepted only when fully idle; the pending key_valid cycle
  // after the last write still counts as part of the expansion.
  assign start_ok = bus.key_start && (state == IDLE) && !fin;
  assign last_wr  = (state == EXPAND) && (idx == last_idx);

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, regardless of statement order between blocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_ok) state_nxt = EXPAND;
      EXPAND:  if (last_wr)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Word counter and status
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx         <= '0;
      fin         <= 1'b0;
      key_valid_q <= 1'b0;
`ifdef DKS_AES256_EN
      aes256_q    <= 1'b0;
`endif
    end else begin
      fin <= 1'b0;
      if (fin) key_valid_q <= 1'b1;
      if (start_ok) begin
        idx         <= {2'b00, nk_new};
        key_valid_q <= 1'b0;
`ifdef DKS_AES256_EN
        aes256_q    <= bus.key_256;
`endif
      end else if (state == EXPAND) begin
        idx <= idx + 6'd1;
        if (last_wr) fin <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Word generator and register file
  // -------------------------------------------------------------------------
  assign w_prev = rf[idx - 6'd1];
  assign w_back = rf[idx - {2'b00, nk}];

  dks_word_gen u_word_gen (
    .w_prev (w_prev),
    .w_back (w_back),
    .i      (idx),
    .nk     (nk),
    .w_next (w_next)
  );

  // NOTE: the round-key storage has no reset; its contents only matter once
  // key_valid is set, and a reset network on every word buys nothing.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      for (int k = 0; k < NK_MAX; k++) begin
        if (4'(k) < nk_new) rf[k] <= bus.key_in[WORD_S*k +: WORD_S];
      end
    end else if (state == EXPAND) begin
      rf[idx] <= w_next;
    end
  end

  // -------------------------------------------------------------------------
  // Read port: one cycle of latency, rounds beyond Nr read as zero
  // -------------------------------------------------------------------------
  assign rd_base = {bus.rd_round, 2'b00};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      round_key_q <= '0;
    end else if (bus.rd_round > rounds_total) begin
      round_key_q <= '0;
    end else begin
      round_key_q <= {rf[rd_base + 6'd3], rf[rd_base + 6'd2],
                      rf[rd_base + 6'd1], rf[rd_base]};
    end
  end

  assign bus.round_key    = round_key_q;
  assign bus.rounds_total = rounds_total;
  assign bus.key_valid    = key_valid_q;
  assign bus.busy         = (state == EXPAND) || fin;

endmodule

// File: tb/tb_dec_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_dec_key_schedule
//   Self-checking bench for dec_key_schedule. Expected round keys come from
//   FIPS-197 constants and from an independent key-expansion model whose
//   S-box is derived from GF(2^8) inversion plus the affine map.
//   AES-256 steps run only when DKS_AES256_EN is defined.
// ---------------------------------------------------------------------------
module tb_dec_key_schedule;

  logic clk;
  logic reset_n;

  dec_key_schedule_if bus ();

  dec_key_schedule dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]   sb [256];
  logic [31:0]  mw [60];
  int           nr_cur;
  logic [127:0] sb_q [$];
  logic [127:0] last_exp;
  bit           have_last;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
    return (v << s) | (v >> (8 - s));
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] m_sub(input logic [31:0] w);
    logic [31:0] s;
    for (int b = 0; b < 4; b++) s[8*b +: 8] = sb[w[8*b +: 8]];
    return s;
  endfunction

  task automatic model_expand(input logic [255:0] key, input int nk);
    logic [31:0] t;
    logic [7:0]  rc;
    int          total;
    total  = (nk == 8) ? 60 : 44;
    nr_cur = (nk == 8) ? 14 : 10;
    rc     = 8'h01;
    for (int i = 0; i < nk; i++) mw[i] = key[32*i +: 32];
    for (int i = nk; i < total; i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t  = m_sub({t[7:0], t[31:8]}) ^ {24'h0, rc};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) begin
        t = m_sub(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] exp_rk(input int r);
    if (r > nr_cur) return 128'h0;
    return {mw[4*r+3], mw[4*r+2], mw[4*r+1], mw[4*r]};
  endfunction

  // FIPS-197 listings put byte 0 leftmost; the bus has byte 0 at [7:0].
  function automatic logic [127:0] brev128(input logic [127:0] v);
    logic [127:0] o;
    for (int b = 0; b < 16; b++) o[8*b +: 8] = v[120-8*b +: 8];
    return o;
  endfunction

  function automatic logic [255:0] brev256(input logic [255:0] v);
    logic [255:0] o;
    for (int b = 0; b < 32; b++) o[8*b +: 8] = v[248-8*b +: 8];
    return o;
  endfunction

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic start_key(input logic [255:0] key, input logic k256);
    bus.key_in    = key;
`ifdef DKS_AES256_EN
    bus.key_256   = k256;
`endif
    bus.key_start = 1'b1;
    @(negedge clk);
    bus.key_start = 1'b0;
    have_last     = 1'b0;
    if (k256 === 1'bx) $display("unexpected key_256 value");
  endtask

  // Counts edges after the key_start edge until key_valid; optionally pulses
  // key_start with a different key after edge pulse_at.
  task automatic wait_valid(input string tag, input int exp_n, input int pulse_at,
                            input logic [255:0] alt_key);
    int n;
    int busy_low;
    busy_low = 0;
    for (n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (bus.key_valid) break;
      if (!bus.busy) busy_low++;
      if (n == pulse_at) begin
        bus.key_in    = alt_key;
        bus.key_start = 1'b1;
      end else if (n == pulse_at + 1) begin
        bus.key_start = 1'b0;
      end
    end
    bus.key_start = 1'b0;
    check({tag, " valid_clk"}, 128'(n), 128'(exp_n));
    check({tag, " busy_gaps"}, 128'(busy_low), 128'h0);
    check({tag, " busy_done"}, 128'(bus.busy), 128'h0);
  endtask

  // One read per cycle: the previous result must still be held just after
  // rd_round changes, and the new one must appear after the next edge.
  task automatic read_rk(input int r, input logic [127:0] exp);
    bus.rd_round = 4'(r);
    if (have_last) begin
      #1;
      check($sformatf("hold before rk[%0d]", r), bus.round_key, last_exp);
    end
    sb_q.push_back(exp);
    @(negedge clk);
    check($sformatf("rk[%0d]", r), bus.round_key, sb_q.pop_front());
    last_exp  = exp;
    have_last = 1'b1;
  endtask

  task automatic sweep(input int hi);
    for (int r = hi; r >= 0; r--) read_rk(r, exp_rk(r));
    read_rk(hi + 1, exp_rk(hi + 1));
    read_rk(15, exp_rk(15));
  endtask

  // ---------------- directed sequence ----------------
  logic [255:0] key_a1, key_c1, key_zero;
`ifdef DKS_AES256_EN
  logic [255:0] key_a3;
`endif

  initial begin
    init_sbox();
    key_a1   = {128'hdeadbeef_cafef00d_01234567_89abcdef,
                brev128(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c)};
    key_c1   = {128'h0, brev128(128'h00010203_04050607_08090a0b_0c0d0e0f)};
    key_zero = '0;
`ifdef DKS_AES256_EN
    key_a3   = brev256(256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4);
    bus.key_256 = 1'b0;
`endif
    reset_n       = 1'b0;
    bus.key_start = 1'b0;
    bus.key_in    = '0;
    bus.rd_round  = '0;
    have_last     = 1'b0;

    // Reset state
    #2;
    check("rst round_key", bus.round_key, 128'h0);
    check("rst rounds_total", 128'(bus.rounds_total), 128'd10);
    check("rst key_valid", 128'(bus.key_valid), 128'h0);
    check("rst busy", 128'(bus.busy), 128'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 1. AES-128 FIPS-197 A.1 (upper key half is garbage and must be ignored)
    model_expand(key_a1, 4);
    start_key(key_a1, 1'b0);
    check("t1 busy_start", 128'(bus.busy), 128'h1);
    wait_valid("t1", 41, 0, '0);
    check("t1 rounds_total", 128'(bus.rounds_total), 128'd10);
    read_rk(0, brev128(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c));
    read_rk(10, brev128(128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6));
    // 3. Read-latency sweep 10..0, then out-of-range rounds
    sweep(10);

`ifdef DKS_AES256_EN
    // 2. AES-256 FIPS-197 A.3
    model_expand(key_a3, 8);
    start_key(key_a3, 1'b1);
    wait_valid("t2", 53, 0, '0);
    check("t2 rounds_total", 128'(bus.rounds_total), 128'd14);
    read_rk(14, brev128(128'hfe4890d1_e6188d0b_046df344_706c631e));
    sweep(14);
`endif

    // 4. key_start pulsed mid-expansion is ignored
    model_expand(key_a1, 4);
    start_key(key_a1, 1'b0);
    wait_valid("t4", 41, 20, key_zero);
    sweep(10);

    // key_start on the cycle of the final word is ignored
    model_expand(key_c1, 4);
    start_key(key_c1, 1'b0);
    wait_valid("t4b", 41, 39, key_a1);
    repeat (3) @(negedge clk);
    check("t4b no_restart busy", 128'(bus.busy), 128'h0);
    check("t4b no_restart valid", 128'(bus.key_valid), 128'h1);
    sweep(10);

    // 5. Reset mid-expansion
    model_expand(key_a1, 4);
    bus.rd_round = 4'd0;
    start_key(key_a1, 1'b0);
    repeat (24) @(negedge clk);
    check("t5 round_key before rst", bus.round_key, exp_rk(0));
    reset_n = 1'b0;
    #1;
    check("t5 rst key_valid", 128'(bus.key_valid), 128'h0);
    check("t5 rst busy", 128'(bus.busy), 128'h0);
    check("t5 rst round_key", bus.round_key, 128'h0);
    check("t5 rst rounds_total", 128'(bus.rounds_total), 128'd10);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t5 idle after rst", 128'(bus.busy), 128'h0);
    start_key(key_a1, 1'b0);
    wait_valid("t5", 41, 0, '0);
    sweep(10);

    // 6. Re-key while key_valid=1 with the all-zero key
    model_expand(key_zero, 4);
    start_key(key_zero, 1'b0);
    check("t6 key_valid drop", 128'(bus.key_valid), 128'h0);
    wait_valid("t6", 41, 0, '0);
    read_rk(1, brev128(128'h62636363_62636363_62636363_62636363));
    sweep(10);
    check("t6 key_valid hold", 128'(bus.key_valid), 128'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed no end, required $finish");
    $fatal(1, "watchdog");
  end

endmodule
